// File: rtl/rc_selftest.sv
// rc_selftest: built-in self-test sequencer for the rc block (z = x | y, w = x & y).
// It drives rc's inputs through the four input combinations. It compares each
// response against the truth table and reports a pass/fail summary.
//
// Parameters:
//   DWELL     - cycles each pattern is held before its response is sampled (>= 1)
//   ERRW      - width of the saturating error counter
// Ports:
//   clock     - system clock, rising-edge active
//   reset     - synchronous active-high reset, has priority over start
//   start     - run request, honoured in IDLE and DONE only
//   x, y      - registered pattern drive into rc
//   z, w      - rc responses
//   busy      - run in progress
//   done      - results valid
//   pass      - done with zero mismatches
//   err_count - mismatching patterns, saturating at all-ones
//   fail_vec  - bit i set when pattern i mismatched
module rc_selftest #(
  parameter int DWELL = 4,
  parameter int ERRW  = 3
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  output logic            x,
  output logic            y,
  input  logic            z,
  input  logic            w,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [ERRW-1:0] err_count,
  output logic [3:0]      fail_vec
);

  localparam int              CNTW     = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(DWELL - 1);
  localparam logic [ERRW-1:0] ERR_MAX  = {ERRW{1'b1}};
  localparam logic [ERRW-1:0] ERR_ZERO = {ERRW{1'b0}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Stimulus for pattern i, returned as {x, y}.
  function automatic logic [1:0] pattern_xy(input logic [1:0] i);
    logic [1:0] r;
    case (i)
      2'd0:    r = 2'b00;
      2'd1:    r = 2'b10;
      2'd2:    r = 2'b01;
      2'd3:    r = 2'b11;
      default: r = 2'b00;
    endcase
    return r;
  endfunction

  // Expected rc response for pattern i, returned as {z, w}.
  function automatic logic [1:0] expected_zw(input logic [1:0] i);
    logic [1:0] r;
    case (i)
      2'd0:    r = 2'b00;
      2'd1:    r = 2'b10;
      2'd2:    r = 2'b10;
      2'd3:    r = 2'b11;
      default: r = 2'b00;
    endcase
    return r;
  endfunction

  state_t          state_r;
  logic [1:0]      idx_r;
  logic [CNTW-1:0] cnt_r;
  logic            x_r;
  logic            y_r;
  logic            busy_r;
  logic            done_r;
  logic            pass_r;
  logic [ERRW-1:0] err_r;
  logic [3:0]      fail_r;

  logic            mismatch_s;
  logic [ERRW-1:0] err_next_s;
  logic [3:0]      fail_next_s;

  // Evaluate the current response and the results it would produce if sampled now.
  always_comb begin
    mismatch_s  = ({z, w} != expected_zw(idx_r));
    fail_next_s = fail_r;
    err_next_s  = err_r;
    if (mismatch_s) begin
      fail_next_s = fail_r | (4'b0001 << idx_r);
      if (err_r != ERR_MAX) begin
        err_next_s = err_r + ERRW'(1'b1);
      end else begin
        err_next_s = err_r;
      end
    end else begin
      fail_next_s = fail_r;
      err_next_s  = err_r;
    end
  end

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= IDLE;
      idx_r   <= 2'd0;
      cnt_r   <= {CNTW{1'b0}};
      x_r     <= 1'b0;
      y_r     <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      pass_r  <= 1'b0;
      err_r   <= ERR_ZERO;
      fail_r  <= 4'b0000;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          if (start) begin
            // A new run always begins from pattern 0 with cleared results.
            state_r    <= RUN;
            idx_r      <= 2'd0;
            cnt_r      <= {CNTW{1'b0}};
            {x_r, y_r} <= pattern_xy(2'd0);
            busy_r     <= 1'b1;
            done_r     <= 1'b0;
            pass_r     <= 1'b0;
            err_r      <= ERR_ZERO;
            fail_r     <= 4'b0000;
          end else begin
            state_r <= state_r;
          end
        end
        RUN: begin
          if (cnt_r == CNT_LAST) begin
            // Last cycle of this pattern: the response is sampled at this edge.
            err_r  <= err_next_s;
            fail_r <= fail_next_s;
            cnt_r  <= {CNTW{1'b0}};
            if (idx_r == 2'd3) begin
              state_r    <= DONE;
              {x_r, y_r} <= 2'b00;
              busy_r     <= 1'b0;
              done_r     <= 1'b1;
              pass_r     <= (err_next_s == ERR_ZERO);
            end else begin
              idx_r      <= idx_r + 2'd1;
              {x_r, y_r} <= pattern_xy(idx_r + 2'd1);
            end
          end else begin
            cnt_r <= cnt_r + CNTW'(1'b1);
          end
        end
        default: begin
          state_r    <= IDLE;
          {x_r, y_r} <= 2'b00;
          busy_r     <= 1'b0;
          done_r     <= 1'b0;
          pass_r     <= 1'b0;
        end
      endcase
    end
  end

  assign x         = x_r;
  assign y         = y_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign pass      = pass_r;
  assign err_count = err_r;
  assign fail_vec  = fail_r;

endmodule
